// File: rtl/arith_pkg.sv
// Shared FSM state type and default widths for the frame accumulator.
package arith_pkg;

    localparam int DEF_DATA_WD = 4;
    localparam int DEF_ACC_WD  = 8;
    localparam int DEF_CNT_WD  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/arith_sat_add.sv
// Combinational signed adder; clamps to the signed range and flags the clamp
// when ACCUM_SAT_EN is defined, otherwise wraps with the flag tied low.
module arith_sat_add #(
    parameter int W = 8
)(
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                clamp
);

`ifdef ACCUM_SAT_EN
    logic signed [W:0] wide;

    assign wide = {a[W-1], a} + {b[W-1], b};

    // Top two bits disagree only when the true sum left the W-bit range.
    always_comb begin
        sum   = wide[W-1:0];
        clamp = 1'b0;
        if (wide[W] != wide[W-1]) begin
            clamp = 1'b1;
            sum   = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    assign sum   = a + b;
    assign clamp = 1'b0;
`endif

endmodule

// File: rtl/arith_accum.sv
// Frame accumulator: sums a length-prefixed burst of add/subtract beats and
// presents the total with a borrow count. Saturation enabled by ACCUM_SAT_EN.
module arith_accum
    import arith_pkg::*;
#(
    parameter int DATA_WD = DEF_DATA_WD,
    parameter int ACC_WD  = DEF_ACC_WD,
    parameter int CNT_WD  = DEF_CNT_WD
)(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [CNT_WD-1:0]   i_len,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [DATA_WD:0]    i_result,
    input  logic                i_mode,
    input  logic                i_ovr,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [ACC_WD-1:0]   o_acc,
    output logic [CNT_WD-1:0]   o_ovr_cnt,
    output logic                o_sat,
    output logic                o_busy
);

    state_t                    state_reg, state_next;
    logic signed [ACC_WD-1:0]  acc_reg, acc_next;
    logic [CNT_WD-1:0]         ovr_cnt_reg, ovr_cnt_next;
    logic [CNT_WD-1:0]         rem_reg, rem_next;
    logic                      sat_reg, sat_next;

    logic signed [ACC_WD-1:0]  beat_val;
    logic signed [ACC_WD-1:0]  sum;
    logic                      clamp;

    // A borrowed subtract result is low bits minus 2^DATA_WD, i.e. {1,low} as signed.
    always_comb begin
        beat_val = ACC_WD'(i_result);
        if (i_mode) begin
            if (i_ovr)
                beat_val = ACC_WD'($signed({1'b1, i_result[DATA_WD-1:0]}));
            else
                beat_val = ACC_WD'(i_result[DATA_WD-1:0]);
        end
    end

    arith_sat_add #(
        .W(ACC_WD)
    ) u_add (
        .a     (acc_reg),
        .b     (beat_val),
        .sum   (sum),
        .clamp (clamp)
    );

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        ovr_cnt_next = ovr_cnt_reg;
        rem_next     = rem_reg;
        sat_next     = sat_reg;
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    acc_next     = '0;
                    ovr_cnt_next = '0;
                    sat_next     = 1'b0;
                    rem_next     = i_len;
                    state_next   = (i_len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (i_valid) begin
                    acc_next = sum;
                    // clamp is tied low in the wrapping build, so this stays 0 there
                    sat_next = sat_reg | clamp;
                    if (i_ovr && (ovr_cnt_reg != '1))
                        ovr_cnt_next = ovr_cnt_reg + CNT_WD'(1);
                    rem_next = rem_reg - CNT_WD'(1);
                    if (rem_reg == CNT_WD'(1))
                        state_next = DONE;
                end
            end
            DONE: begin
                if (i_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            ovr_cnt_reg <= '0;
            rem_reg     <= '0;
            sat_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            ovr_cnt_reg <= ovr_cnt_next;
            rem_reg     <= rem_next;
            sat_reg     <= sat_next;
        end
    end

    assign o_ready   = (state_reg == ACCUM);
    assign o_valid   = (state_reg == DONE);
    assign o_busy    = (state_reg != IDLE);
    assign o_acc     = acc_reg;
    assign o_ovr_cnt = ovr_cnt_reg;
    assign o_sat     = sat_reg;

endmodule

// File: doc/arith_accum.md
ARITH_ACCUM -- requirements
Module: arith_accum

Interface
REQ-001 SHALL have parameter DATA_WD, default 4, operand width of the upstream adder/subtractor (result width DATA_WD+1).
REQ-002 SHALL have parameter ACC_WD, default 8, signed accumulator width.
REQ-003 SHALL have parameter CNT_WD, default 4, beat-length and overflow-count width.
REQ-004 i_clk  input  1  sole clock, rising edge.
REQ-005 i_rst  input  1  synchronous, active-high reset.
REQ-006 i_start  input  1  frame start request, sampled only in IDLE.
REQ-007 i_len  input  CNT_WD  beats in frame, sampled with i_start.
REQ-008 i_valid  input  1  upstream result beat valid.
REQ-009 o_ready  output  1  beat accepted when i_valid and o_ready are both high.
REQ-010 i_result  input  DATA_WD+1  upstream arithmetic result.
REQ-011 i_mode  input  1  0 = add beat, 1 = subtract beat.
REQ-012 i_ovr  input  1  upstream borrow flag (subtract with a<b).
REQ-013 o_valid  output  1  frame result valid.
REQ-014 i_ready  input  1  downstream accepts frame result.
REQ-015 o_acc  output  ACC_WD  signed accumulated sum.
REQ-016 o_ovr_cnt  output  CNT_WD  count of beats with i_ovr=1.
REQ-017 o_sat  output  1  sticky saturation flag for current frame.
REQ-018 o_busy  output  1  high in any state other than IDLE.

Function
REQ-019 Beat value SHALL be: mode 0 -> zero-extended i_result; mode 1, i_ovr 0 -> zero-extended i_result[DATA_WD-1:0]; mode 1, i_ovr 1 -> i_result[DATA_WD-1:0] minus 2^DATA_WD (negative).
REQ-020 FSM states SHALL be IDLE, ACCUM, DONE; state, accumulator, counters all registered.
REQ-021 IDLE: o_ready=0, o_valid=0; on i_start, clear o_acc, o_ovr_cnt, o_sat, load remaining=i_len; go ACCUM, or DONE if i_len=0.
REQ-022 ACCUM: o_ready=1; each accepted beat adds beat value to o_acc, increments o_ovr_cnt if i_ovr (saturating at all-ones), decrements remaining; on the beat taking remaining to 0, go DONE.
REQ-023 o_valid SHALL assert in the cycle after the last beat is accepted (one-cycle latency) and o_acc/o_ovr_cnt/o_sat SHALL be final in that cycle.
REQ-024 DONE: o_valid=1, outputs held stable while i_ready=0; on i_ready=1 go IDLE next cycle.
REQ-025 i_start outside IDLE SHALL be ignored; i_valid outside ACCUM SHALL be ignored (no accept).
REQ-026 i_start and i_valid in same IDLE cycle: no beat accepted that cycle.
REQ-027 ACCUM with i_valid=0 SHALL hold all state indefinitely.

Reset
REQ-028 i_rst SHALL force IDLE, o_acc=0, o_ovr_cnt=0, o_sat=0, o_valid=0, o_ready=0, o_busy=0, remaining=0, from any state including mid-frame.

Configuration
REQ-029 With ACCUM_SAT_EN defined, accumulation SHALL clamp to [-2^(ACC_WD-1), 2^(ACC_WD-1)-1] and set o_sat on any clamp.
REQ-030 Without ACCUM_SAT_EN, accumulation SHALL wrap modulo 2^ACC_WD and o_sat SHALL be constant 0.

Structure
REQ-031 Package arith_pkg SHALL hold the FSM state enum typedef and default width constants.
REQ-032 Sub-module arith_sat_add SHALL implement the combinational signed add with optional clamp and clamp flag.

Verification (DATA_WD=4, ACC_WD=8, CNT_WD=4)
REQ-033 start len=3; beats (m0,17),(m0,3),(m1,ovr0,4) -> o_valid cycle after 3rd accept, o_acc=24, o_ovr_cnt=0, o_sat=0.
REQ-034 start len=2; two beats (m1,ovr1,result 13) -> o_acc=8'hFA (-6), o_ovr_cnt=2.
REQ-035 start len=8; eight beats (m0,31) -> with ACCUM_SAT_EN o_acc=127, o_sat=1; without o_acc=8'hF8, o_sat=0.
REQ-036 start len=0 -> DONE next cycle, o_acc=0, o_ready never high.
REQ-037 i_ready=0 for 5 cycles in DONE plus i_start pulse -> o_valid and outputs stable, no new frame; i_rst after 2 beats of len=4 frame -> next cycle o_busy=0, o_acc=0.
